avalon_msg_framer: RTL and testbench
====================================

// Module: avalon_msg_framer
// PURPOSE
//  Transmit-side counterpart of the Avalon-ST enforcement logic.
//  - Takes a byte-length command and an unframed word stream.
//  - Emits well-formed Avalon-ST messages: one sop, one eop, correct empty.
//  - Sits in front of any link whose sink runs the sop/eop enforcer, so a
//    correctly framed source never trips missing/double-sop checks.
// PARAMETERS
//  DATA_WIDTH_IN_BYTES  16  bytes per beat; power of 2, >= 2
//  LEN_WIDTH            16  width of cmd_len_bytes and internal word counter
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  rst            in   1       synchronous, active-low reset (0 = reset)
//  cmd_valid      in   1       command present
//  cmd_len_bytes  in   LEN_WIDTH  message length in bytes
//  cmd_rdy        out  1       command accepted when cmd_valid && cmd_rdy
//  raw_data       if   avalon_st_if.slave   unframed words; only data/valid/rdy used
//  framed_msg     if   avalon_st_if.master  framed output: data/valid/sop/eop/empty
//  zero_len_error out  1       1-cycle pulse: zero-length command dropped
//  msg_active     out  1       1 while state == SEND
//  msg_count      out  16      completed messages; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - state=IDLE.
//  - framed_msg.valid/sop/eop=0; data='0; empty=0.
//  - zero_len_error=0; msg_count=0; internal counters=0.
//  Transfer rule: a beat moves on any port iff valid && rdy at the posedge.
//  FSM IDLE:
//  - cmd_rdy=1; raw_data.rdy=0.
//  - cmd accepted, len!=0: latch words_left=ceil(len/W),
//    last_empty=(W - len%W)%W, first=1; go to SEND.
//  - cmd accepted, len==0: zero_len_error=1 for one cycle; stay IDLE.
//  FSM SEND:
//  - cmd_rdy=0.
//  - out_free = !framed_msg.valid || framed_msg.rdy.
//  - raw_data.rdy = out_free (combinational from framed_msg.rdy).
//  - On each accepted raw beat, the output register loads:
//    data=raw data; valid=1; sop=first; eop=(words_left==1);
//    empty = eop ? last_empty : 0.
//    Then first<=0 and words_left<=words_left-1.
//  - Beat with eop loaded: msg_count++, state<=IDLE the same edge.
//  Output register:
//  - Latency: raw beat accepted at edge N appears on framed_msg after
//    edge N, i.e. 1 cycle.
//  - While valid && !rdy, data/sop/eop/empty/valid are held stable.
//  - If out_free and no raw beat is loaded, valid<=0 (bubble).
//    Bubbles are legal mid-message; sop/eop are only ever asserted with valid.
//  - Output not consumed on exit to IDLE: the last beat stays held until
//    rdy. A new command may be accepted meanwhile, but its first beat
//    waits for out_free.
//  Boundaries:
//  - len a multiple of W: empty=0 on eop.
//  - len<=W: single beat with sop=eop=1.
//  - Max len 2^LEN_WIDTH-1: word counter width LEN_WIDTH, no overflow.
//  - Reset mid-message: message truncated without eop, output cleared,
//    msg_count not incremented. The next message starts with sop.
//  - Extra raw beats after eop are not accepted (raw_data.rdy=0 in IDLE).
// TESTING  (W=16, framed_msg.rdy=1 unless stated)
//  1. len=40, continuous raw words D0..D2 -> 3 beats D0..D2; sop on D0,
//     eop+empty=8 on D2; valid 1 cycle after each raw accept; msg_count=1.
//  2. len=16 -> single beat, sop=eop=1, empty=0; msg_active high 1 cycle.
//  3. len=0 -> zero_len_error high exactly 1 cycle; no framed beat;
//     cmd_rdy stays 1.
//  4. len=48, framed_msg.rdy toggling 1,0,1,0 -> beats held stable while
//     stalled; raw_data.rdy=0 on stall; 3 beats in order, eop on third.
//  5. Back-to-back cmds len=17 then len=1 -> beats (sop), (eop,empty=15),
//     (sop,eop,empty=15); never two sops without an eop; msg_count=2.
//  6. rst=0 one cycle after first beat of len=64 -> next cycle valid=0,
//     cmd_rdy=1, msg_count=0; a following len=16 cmd is emitted with sop=1.

Source files
------------

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: data, valid/rdy handshake and sop/eop/empty framing.
// A beat transfers on any port iff valid && rdy at the rising clock edge.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_framer.sv
// Frames an unframed word stream into Avalon-ST messages (one sop, one eop,
// correct empty) from a byte-length command, through a 1-deep output register.
module avalon_msg_framer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [LEN_WIDTH-1:0] cmd_len_bytes,
  output logic                 cmd_rdy,
  avalon_st_if.slave           raw_data,
  avalon_st_if.master          framed_msg,
  output logic                 zero_len_error,
  output logic                 msg_active,
  output logic [15:0]          msg_count
);
  localparam int W  = DATA_WIDTH_IN_BYTES;
  localparam int DW = 8 * W;
  localparam int EW = $clog2(W);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state, state_nxt;
  logic                 out_free, cmd_fire, raw_fire, last_word;
  logic [DW-1:0]        out_data;
  logic                 out_valid, out_sop, out_eop;
  logic [EW-1:0]        out_empty;
  logic [LEN_WIDTH-1:0] words_left, words_init;
  logic [EW-1:0]        last_empty, last_empty_init;
  logic                 first;

  assign out_free  = !out_valid || framed_msg.rdy;
  assign cmd_fire  = cmd_valid && cmd_rdy;
  assign raw_fire  = raw_data.valid && raw_data.rdy;
  assign last_word = (words_left == LEN_WIDTH'(1));

  // ceil(len/W) and (W - len%W) % W; the latter is the two's complement of
  // the low byte-offset bits, which is already 0 for whole-word lengths.
  assign words_init      = (cmd_len_bytes >> EW) + LEN_WIDTH'(|cmd_len_bytes[EW-1:0]);
  assign last_empty_init = '0 - cmd_len_bytes[EW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire && (cmd_len_bytes != '0)) state_nxt = SEND;
      SEND: if (raw_fire && last_word)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy      = 1'b0;
    raw_data.rdy = 1'b0;
    msg_active   = 1'b0;
    case (state)
      IDLE: cmd_rdy = 1'b1;
      SEND: begin
        raw_data.rdy = out_free;
        msg_active   = 1'b1;
      end
      default: cmd_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_sop        <= 1'b0;
      out_eop        <= 1'b0;
      out_empty      <= '0;
      words_left     <= '0;
      last_empty     <= '0;
      first          <= 1'b0;
      zero_len_error <= 1'b0;
      msg_count      <= '0;
    end else begin
      zero_len_error <= cmd_fire && (cmd_len_bytes == '0);
      if (cmd_fire && (cmd_len_bytes != '0)) begin
        words_left <= words_init;
        last_empty <= last_empty_init;
        first      <= 1'b1;
      end
      if (raw_fire) begin
        out_data   <= raw_data.data;
        out_valid  <= 1'b1;
        out_sop    <= first;
        out_eop    <= last_word;
        out_empty  <= last_word ? last_empty : '0;
        first      <= 1'b0;
        words_left <= words_left - LEN_WIDTH'(1);
        if (last_word) msg_count <= msg_count + 16'd1;
      end else if (out_free) begin
        // Bubble: framing flags never outlive the beat they belong to.
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        out_empty <= '0;
      end
    end
  end

  assign framed_msg.data  = out_data;
  assign framed_msg.valid = out_valid;
  assign framed_msg.sop   = out_sop;
  assign framed_msg.eop   = out_eop;
  assign framed_msg.empty = out_empty;
endmodule

// File: tb/tb_avalon_msg_framer.sv
// Bench for avalon_msg_framer: table vectors, hand-written corner sequences and
// randomized traffic scored against a message-level model of the framing rules.
module tb_avalon_msg_framer;
  localparam int W  = 16;
  localparam int DW = 8 * W;
  localparam int EW = 4;
  localparam int LW = 16;
  localparam int BW = DW + 2 + EW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len_bytes = '0;
  logic          cmd_rdy, zero_len_error, msg_active;
  logic [15:0]   msg_count;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) raw_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) framed_if ();

  avalon_msg_framer #(.DATA_WIDTH_IN_BYTES(W), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_len_bytes  (cmd_len_bytes),
    .cmd_rdy        (cmd_rdy),
    .raw_data       (raw_if),
    .framed_msg     (framed_if),
    .zero_len_error (zero_len_error),
    .msg_active     (msg_active),
    .msg_count      (msg_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int len;
    int beats;
    int empty;
  } vec_t;

  logic [BW-1:0] exp_q[$];
  logic [DW-1:0] raw_q[$];
  int  n_checks = 0, n_pass = 0;
  int  exp_msg = 0, exp_zero = 0, zero_seen = 0, active_cycles = 0;
  int  rdy_mode = 0;
  bit  mon_en = 1'b0, raw_rand = 1'b0, raw_fire_s = 1'b0;
  bit  lat_pending = 1'b0, hold_pending = 1'b0;
  logic [BW:0]   held, mon_cur;
  logic [BW-1:0] mon_exp;

  task automatic check(input bit ok, input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a message of len bytes is ceil(len/W) beats of raw words in order,
  // sop on the first, eop on the last with empty = (W - len%W) % W.
  function automatic void plan_fixed(input int beats, input int empty);
    logic [DW-1:0] w;
    for (int i = 0; i < beats; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      raw_q.push_back(w);
      exp_q.push_back({w, (i == 0), (i == beats - 1), (i == beats - 1) ? EW'(empty) : EW'(0)});
    end
    exp_msg++;
  endfunction

  function automatic void plan_model(input int len);
    if (len == 0) exp_zero++;
    else plan_fixed((len + W - 1) / W, (W - len % W) % W);
  endfunction

  // ---------------- drivers ----------------
  initial begin
    raw_if.valid = 1'b0;
    raw_if.data  = '0;
    raw_if.sop   = 1'b0;
    raw_if.eop   = 1'b0;
    raw_if.empty = '0;
    forever begin
      @(posedge clk); #1;
      if (raw_fire_s && raw_q.size() > 0) void'(raw_q.pop_front());
      if (raw_q.size() > 0 && (!raw_rand || $urandom_range(0, 3) != 0)) begin
        raw_if.valid = 1'b1;
        raw_if.data  = raw_q[0];
      end else begin
        raw_if.valid = 1'b0;
      end
    end
  end

  initial begin
    framed_if.rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       framed_if.rdy = ($urandom_range(0, 3) != 0);
        2:       framed_if.rdy = ~framed_if.rdy;
        default: framed_if.rdy = 1'b1;
      endcase
    end
  end

  task automatic send_cmd(input int len);
    bit fired = 1'b0;
    int n = 0;
    cmd_valid     = 1'b1;
    cmd_len_bytes = LW'(len);
    while (!fired && n < 5000) begin
      @(negedge clk);
      fired = cmd_rdy;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!fired) check(1'b0, "cmd_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || raw_q.size() != 0 || msg_active || framed_if.valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check(1'b0, "drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clk) begin
    mon_cur    = {framed_if.valid, framed_if.data, framed_if.sop, framed_if.eop, framed_if.empty};
    raw_fire_s = raw_if.valid && raw_if.rdy;
    if (!mon_en) begin
      lat_pending  = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (lat_pending) check(framed_if.valid == 1'b1, "latency_valid", framed_if.valid, 1);
      lat_pending = raw_fire_s;
      if (hold_pending) check(mon_cur == held, "stall_hold", mon_cur, held);
      hold_pending = framed_if.valid && !framed_if.rdy;
      held         = mon_cur;
      if (framed_if.valid && !framed_if.rdy) check(raw_if.rdy == 1'b0, "raw_rdy_stall", raw_if.rdy, 0);
      check(framed_if.valid || (!framed_if.sop && !framed_if.eop), "flags_without_valid",
            {framed_if.sop, framed_if.eop}, 0);
      if (framed_if.valid && framed_if.rdy) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected_beat", mon_cur, 0);
        else begin
          mon_exp = exp_q.pop_front();
          check(mon_cur[BW-1:0] == mon_exp, "beat", mon_cur[BW-1:0], mon_exp);
        end
      end
      if (zero_len_error) zero_seen++;
      if (msg_active) active_cycles++;
    end
  end

  // ---------------- test sequence ----------------
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{len: 40,    beats: 3,    empty: 8};
    vecs[1]  = '{len: 16,    beats: 1,    empty: 0};
    vecs[2]  = '{len: 17,    beats: 2,    empty: 15};
    vecs[3]  = '{len: 1,     beats: 1,    empty: 15};
    vecs[4]  = '{len: 48,    beats: 3,    empty: 0};
    vecs[5]  = '{len: 64,    beats: 4,    empty: 0};
    vecs[6]  = '{len: 33,    beats: 3,    empty: 15};
    vecs[7]  = '{len: 15,    beats: 1,    empty: 1};
    vecs[8]  = '{len: 100,   beats: 7,    empty: 12};
    vecs[9]  = '{len: 32,    beats: 2,    empty: 0};
    vecs[10] = '{len: 65535, beats: 4096, empty: 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(framed_if.valid == 1'b0, "rst_valid", framed_if.valid, 0);
    check({framed_if.sop, framed_if.eop, framed_if.empty} == '0, "rst_flags",
          {framed_if.sop, framed_if.eop, framed_if.empty}, 0);
    check(framed_if.data == '0, "rst_data", framed_if.data, 0);
    check(cmd_rdy == 1'b1, "rst_cmd_rdy", cmd_rdy, 1);
    check(raw_if.rdy == 1'b0, "rst_raw_rdy", raw_if.rdy, 0);
    check(msg_count == 16'd0, "rst_msg_count", msg_count, 0);
    check(zero_len_error == 1'b0 && msg_active == 1'b0, "rst_pulses", {zero_len_error, msg_active}, 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Table vectors: continuous raw data, sink always ready
    for (int i = 0; i < 11; i++) begin
      active_cycles = 0;
      plan_fixed(vecs[i].beats, vecs[i].empty);
      send_cmd(vecs[i].len);
      wait_idle(6000);
      check(active_cycles == vecs[i].beats, "active_cycles", active_cycles, vecs[i].beats);
      check(msg_count == 16'(exp_msg), "msg_count_vec", msg_count, exp_msg);
    end

    // Zero-length command
    zero_seen = 0;
    send_cmd(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(zero_seen == 1, "zero_len_pulse", zero_seen, 1);
    check(cmd_rdy == 1'b1, "zero_len_cmd_rdy", cmd_rdy, 1);
    check(framed_if.valid == 1'b0, "zero_len_no_beat", framed_if.valid, 0);
    check(msg_count == 16'(exp_msg), "zero_len_count", msg_count, exp_msg);
    @(posedge clk); #1;

    // Toggling sink ready
    rdy_mode = 2;
    plan_model(48);
    send_cmd(48);
    wait_idle(500);
    check(msg_count == 16'(exp_msg), "msg_count_toggle", msg_count, exp_msg);

    // Back-to-back commands
    rdy_mode = 0;
    plan_model(17);
    send_cmd(17);
    plan_model(1);
    send_cmd(1);
    wait_idle(500);
    check(msg_count == 16'(exp_msg), "msg_count_b2b", msg_count, exp_msg);

    // Reset in the middle of a 4-beat message
    begin
      int n = 0;
      plan_model(64);
      send_cmd(64);
      while (exp_q.size() > 3 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check(exp_q.size() == 3, "first_beat_seen", exp_q.size(), 3);
    end
    rst    = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    raw_q.delete();
    raw_if.valid = 1'b0;
    exp_msg = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check(framed_if.valid == 1'b0, "midrst_valid", framed_if.valid, 0);
    check(cmd_rdy == 1'b1, "midrst_cmd_rdy", cmd_rdy, 1);
    check(msg_count == 16'd0, "midrst_msg_count", msg_count, 0);
    check(msg_active == 1'b0, "midrst_active", msg_active, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    plan_model(16);
    send_cmd(16);
    wait_idle(500);
    check(msg_count == 16'(exp_msg), "midrst_next_msg", msg_count, exp_msg);

    // Randomized traffic
    rdy_mode  = 1;
    raw_rand  = 1'b1;
    zero_seen = 0;
    exp_zero  = 0;
    for (int k = 0; k < 40; k++) begin
      int len;
      case ($urandom_range(0, 4))
        0:       len = 0;
        1:       len = W * $urandom_range(1, 6);
        default: len = $urandom_range(1, 120);
      endcase
      plan_model(len);
      send_cmd(len);
    end
    wait_idle(5000);
    check(zero_seen == exp_zero, "rand_zero_len", zero_seen, exp_zero);
    check(msg_count == 16'(exp_msg), "rand_msg_count", msg_count, exp_msg);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
